// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch requester. Holds the PC, keeps at most one
// request outstanding to instruction memory, buffers returned words in a small
// FIFO for decode, and drops stale in-flight data after a branch/jump redirect.
//
// Handshakes:
//   imem side   - a request transfers at a posedge where imem_enable=1 and
//                 imem_ready=1; imem_data is captured at that same edge.
//                 imem_addr stays constant while imem_enable=1 and imem_ready=0.
//   decode side - the head entry transfers at a posedge where instr_valid=1
//                 and instr_accept=1; instr_accept while empty has no effect.
module ifetch_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                INSTR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_enable,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_accept,
    output logic [1:0]         dbg_state_o
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        KILL = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   count_q, count_d, count_after;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [INSTR_W-1:0] data_mem_q [BUF_DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q   [BUF_DEPTH];
    logic               accept, pop, push;

    // Outputs come straight from registers.
    assign imem_enable = (state_q != IDLE);
    assign imem_addr   = addr_q;
    assign instr_valid = (count_q != '0);
    assign instr_data  = data_mem_q[rd_ptr_q];
    assign instr_pc    = pc_mem_q[rd_ptr_q];
    assign dbg_state_o = state_q;

    // A redirect flushes the FIFO, so it suppresses any same-cycle push or pop.
    assign accept      = imem_enable & imem_ready;
    assign pop         = instr_valid & instr_accept & ~redirect_valid;
    assign push        = accept & (state_q == REQ) & ~redirect_valid;
    assign count_after = count_q + CNT_W'(push) - CNT_W'(pop);

    // Next-state, PC and FIFO pointer logic.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_after;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

        if (redirect_valid) begin
            pc_d     = redirect_pc & ~ADDR_W'(3);
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            unique case (state_q)
                IDLE:    state_d = REQ;
                REQ:     state_d = accept ? REQ : KILL;
                // If the stale request completes on this very edge there is
                // nothing left in flight, so the new target can be fetched.
                KILL:    state_d = imem_ready ? REQ : KILL;
                default: state_d = IDLE;
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    if ((count_q < DEPTH_C) || pop) begin
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (accept) begin
                        pc_d    = pc_q + ADDR_W'(4);
                        state_d = (count_after < DEPTH_C) ? REQ : IDLE;
                    end
                end
                KILL: begin
                    // Stale response is discarded; no push happens in KILL.
                    if (imem_ready) begin
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // In KILL the outstanding stale address must stay on the bus.
        addr_d = (state_d == KILL) ? addr_q : pc_d;
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                data_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else if (push) begin
            data_mem_q[wr_ptr_q] <= imem_data;
            pc_mem_q[wr_ptr_q]   <= addr_q;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed bench for ifetch_unit with a wait-state memory
// model and an in-order scoreboard of expected fetch PCs.
module tb_ifetch_unit;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_KILL = 2'd2;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_enable;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_accept;
    logic [1:0]  dbg_state;

    int          n_checks;
    int          n_bad;
    int          wait_cycles;
    int          wcnt;
    logic        force_ready;
    logic [31:0] exp_q[$];

    ifetch_unit #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (32'h0),
        .BUF_DEPTH(2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_enable   (imem_enable),
        .imem_data     (imem_data),
        .imem_ready    (imem_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .instr_accept  (instr_accept),
        .dbg_state_o   (dbg_state)
    );

    // Clock: posedges at 5,15,25...; inputs change on negedges.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic fill_q(input logic [31:0] base);
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(base + 32'(4 * i));
        end
    endtask

    // Pulse reset, then release it on a negedge with the new settings.
    task automatic restart(input int wc, input logic acc);
        @(negedge clk);
        reset          = 1'b1;
        instr_accept   = 1'b0;
        redirect_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        wait_cycles  = wc;
        instr_accept = acc;
        fill_q(32'h0);
        reset        = 1'b0;
    endtask

    // Memory model: answers after wait_cycles idle cycles per request.
    initial begin
        imem_ready = 1'b0;
        imem_data  = '0;
        wcnt       = 0;
        forever begin
            @(negedge clk);
            if (imem_ready) wcnt = 0;
            if (force_ready) begin
                imem_ready = 1'b1;
                imem_data  = mem_word(imem_addr);
            end else if (!imem_enable) begin
                imem_ready = 1'b0;
                wcnt       = 0;
            end else if (wcnt >= wait_cycles) begin
                imem_ready = 1'b1;
                imem_data  = mem_word(imem_addr);
            end else begin
                imem_ready = 1'b0;
                wcnt++;
            end
        end
    end

    // Scoreboard: every decode pop must match the next expected PC and word.
    initial begin
        logic [31:0] exp_pc;
        forever begin
            @(negedge clk);
            #1;
            if (!reset && !redirect_valid && instr_valid && instr_accept) begin
                exp_pc = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                check_eq("pop_pc", instr_pc, exp_pc);
                check_eq("pop_data", instr_data, mem_word(exp_pc));
            end
        end
    end

    initial begin
        n_checks       = 0;
        n_bad          = 0;
        reset          = 1'b1;
        instr_accept   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        wait_cycles    = 0;
        force_ready    = 1'b0;

        // Reset values
        @(negedge clk);
        #2;
        check_eq("rst_enable", imem_enable, 0);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_valid", instr_valid, 0);
        check_eq("rst_data", instr_data, 0);
        check_eq("rst_pc", instr_pc, 0);
        check_eq("rst_state", dbg_state, ST_IDLE);

        // Zero-wait memory, decode always accepting: one address per cycle
        restart(0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #2;
            check_eq("stream_en", imem_enable, 1);
            check_eq("stream_addr", imem_addr, 32'(4 * k));
        end

        // Decode stalled: two words buffered, then idle at pc 8
        restart(0, 1'b0);
        @(negedge clk); #2;
        check_eq("stall_addr0", imem_addr, 32'h0);
        @(negedge clk); #2;
        check_eq("stall_addr1", imem_addr, 32'h4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #2;
            check_eq("stall_en", imem_enable, 0);
            check_eq("stall_addr", imem_addr, 32'h8);
            check_eq("stall_state", dbg_state, ST_IDLE);
            check_eq("stall_head", instr_pc, 32'h0);
        end
        @(negedge clk);
        instr_accept = 1'b1;
        for (int k = 0; k < 5; k++) @(negedge clk);
        #2;
        check_eq("resume_en", imem_enable, 1);
        check_eq("resume_next", exp_q[0], 32'h18);

        // Three wait states: address held, one word per four cycles
        restart(3, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); #2;
            check_eq("wait_addr", imem_addr, 32'(4 * ((k - 1) / 4)));
        end
        // Redirect while the request for 0x8 is still waiting
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        exp_q.delete();
        fill_q(32'h40);
        #2;
        check_eq("redir_addr8", imem_addr, 32'h8);
        @(negedge clk);
        redirect_valid = 1'b0;
        #2;
        check_eq("kill_state", dbg_state, ST_KILL);
        check_eq("kill_en", imem_enable, 1);
        for (int k = 0; k < 3; k++) begin
            check_eq("kill_addr", imem_addr, 32'h8);
            check_eq("kill_valid", instr_valid, 0);
            @(negedge clk); #2;
        end
        check_eq("after_kill_state", dbg_state, ST_REQ);
        check_eq("after_kill_addr", imem_addr, 32'h40);
        for (int k = 0; k < 4; k++) begin
            check_eq("refetch_valid", instr_valid, 0);
            @(negedge clk); #2;
        end
        check_eq("refetch_head_valid", instr_valid, 1);
        check_eq("refetch_head_pc", instr_pc, 32'h40);

        // Redirect with the FIFO full, a pop and imem_ready in the same cycle
        restart(0, 1'b0);
        for (int k = 0; k < 3; k++) @(negedge clk);
        #2;
        check_eq("full_state", dbg_state, ST_IDLE);
        check_eq("full_valid", instr_valid, 1);
        force_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        instr_accept   = 1'b1;
        exp_q.delete();
        fill_q(32'h100);
        #2;
        force_ready = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b0;
        #2;
        check_eq("flush_valid", instr_valid, 0);
        check_eq("flush_addr", imem_addr, 32'h100);
        check_eq("flush_en", imem_enable, 1);
        check_eq("flush_state", dbg_state, ST_REQ);
        for (int k = 0; k < 3; k++) @(negedge clk);
        #2;
        check_eq("flush_next", exp_q[0], 32'h10C);

        // Reset during a wait-state request
        restart(3, 1'b1);
        @(negedge clk);
        @(negedge clk); #2;
        check_eq("mid_en", imem_enable, 1);
        check_eq("mid_addr", imem_addr, 32'h0);
        #1;
        reset = 1'b1;
        #1;
        check_eq("async_en", imem_enable, 0);
        check_eq("async_valid", instr_valid, 0);
        check_eq("async_state", dbg_state, ST_IDLE);
        @(negedge clk);
        wait_cycles = 0;
        exp_q.delete();
        fill_q(32'h0);
        reset = 1'b0;
        @(negedge clk); #2;
        check_eq("restart_en", imem_enable, 1);
        check_eq("restart_addr", imem_addr, 32'h0);
        @(negedge clk); #2;
        check_eq("restart_addr1", imem_addr, 32'h4);
        check_eq("restart_valid", instr_valid, 1);
        @(negedge clk); #2;
        check_eq("restart_next", exp_q[0], 32'h8);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
